out_display: RTL and testbench

- Consumes the CPU's registered `out` word and presents it on a multiplexed decimal seven-segment display.
- On each change of the input value, a sequential shift-add-3 (double-dabble) converter produces packed BCD digits.
- A prescaled scanner walks the digits, driving one-hot anode enables and segment patterns, with leading-zero blanking.
- Sits directly downstream of the CPU `out` port, at the board-level top.

---
 rtl/out_display_if.sv | 16 +
 rtl/out_display.sv | 150 +++++++++++++++
 tb/tb_out_display.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_display_if.sv
// Bus between the CPU `out` port and the seven-segment display block.
// master drives the binary value; slave returns BCD, status and display drive.
interface out_display_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
);
    logic [DATA_WIDTH-1:0] value;
    logic [4*DIGITS-1:0]   bcd;
    logic                  done;
    logic                  busy;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;

    modport master (output value, input bcd, done, busy, an, seg);
    modport slave  (input value, output bcd, done, busy, an, seg);
endinterface

// File: rtl/out_display.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a multiplexed
// seven-segment scanner with leading-zero blanking.
module out_display #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5,
    parameter int SCAN_DIV   = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    out_display_if.slave  disp
);
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] last_value_q, last_value_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         work_q, work_d, adj;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     blank;
    logic                  hi_zero;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0: enc = 7'h3F;
            4'd1: enc = 7'h06;
            4'd2: enc = 7'h5B;
            4'd3: enc = 7'h4F;
            4'd4: enc = 7'h66;
            4'd5: enc = 7'h6D;
            4'd6: enc = 7'h7D;
            4'd7: enc = 7'h07;
            4'd8: enc = 7'h7F;
            4'd9: enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // Add-3 correction is taken from the pre-shift work register.
    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++)
            if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end

    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        shift_d      = shift_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (disp.value != last_value_q) begin
                    last_value_d = disp.value;
                    shift_d      = disp.value;
                    work_d       = '0;
                    cnt_d        = '0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                work_d  = {adj[BW-2:0], shift_q[DATA_WIDTH-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A digit is blank when it and every digit above it are zero; units never blank.
    always_comb begin
        blank   = '0;
        hi_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero  = hi_zero && (bcd_q[4*k +: 4] == 4'd0);
            blank[k] = hi_zero && (k != 0);
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = '0;
        seg_d = 7'h00;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                an_d[k] = 1'b1;
                seg_d   = blank[k] ? 7'h00 : enc(bcd_q[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_value_q <= '0;
            shift_q      <= '0;
            work_q       <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            done_q       <= 1'b0;
            pre_q        <= '0;
            idx_q        <= '0;
            an_q         <= DIGITS'(1);
            seg_q        <= 7'h3F;
        end else begin
            state_q      <= state_d;
            last_value_q <= last_value_d;
            shift_q      <= shift_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            done_q       <= done_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign disp.bcd  = bcd_q;
    assign disp.done = done_q;
    assign disp.busy = (state_q != IDLE);
    assign disp.an   = an_q;
    assign disp.seg  = seg_q;
endmodule

// File: tb/tb_out_display.sv
// Bench for out_display: scoreboard of expected BCD results checked on done,
// plus directed latency, scanner, collapse and reset-abort cases.
module tb_out_display;
    localparam int DW = 16;
    localparam int DG = 5;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    out_display_if #(.DATA_WIDTH(DW), .DIGITS(DG)) dif ();
    out_display #(.DATA_WIDTH(DW), .DIGITS(DG), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .disp(dif)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cur = 0;
    logic [19:0] exp_q[$];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DG; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && dif.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got bcd=%h expected no done", dif.bcd);
            end else begin
                check("done_bcd", 32'(dif.bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !dif.busy) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    endtask

    task automatic convert(input int v);
        dif.value = DW'(v);
        exp_q.push_back(to_bcd(v));
        drain();
        cur = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(dif.an), 32'h1);
        check({tag, "_seg"}, 32'(dif.seg), 32'h3F);
        check({tag, "_bcd"}, 32'(dif.bcd), 32'h0);
        check({tag, "_busy"}, 32'(dif.busy), 32'h0);
        check({tag, "_done"}, 32'(dif.done), 32'h0);
    endtask

    // Expects bcd to hold v; follows one full scan cycle from digit 0.
    task automatic scan_check(input int v);
        logic [DG-1:0] prev;
        logic [6:0] es [DG];
        bit found;
        int p, q;
        p = 1;
        for (int k = 0; k < DG; k++) begin
            q = v / p;
            es[k] = (k > 0 && q == 0) ? 7'h00 : seg_tab[q % 10];
            p = p * 10;
        end
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            prev = dif.an;
            @(negedge clk);
            if (prev != 1 && dif.an == 1) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_sync: got an=%b expected wrap to 00001", dif.an);
            return;
        end
        for (int i = 0; i < SD * DG + SD; i++) begin
            check("scan_an", 32'(dif.an), 32'(1 << ((i / SD) % DG)));
            check("scan_seg", 32'(dif.seg), 32'(es[(i / SD) % DG]));
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, d0, v, w, n;
        bit got;
        dif.value = '0;
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dif.busy) got = 1;
        end
        check("idle_no_convert", 32'(got), 32'h0);

        // Latency: done appears exactly after the 17th edge, for one cycle.
        dif.value = 16'd12345;
        exp_q.push_back(to_bcd(12345));
        @(posedge clk); #1;
        check("busy_after_e0", 32'(dif.busy), 32'h1);
        lat = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (dif.done) got = 1;
        end
        check("latency", 32'(lat), 32'd17);
        check("bcd_12345", 32'(dif.bcd), 32'h12345);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(dif.done), 32'h0);
        drain();
        cur = 12345;

        convert(65535);
        check("bcd_65535", 32'(dif.bcd), 32'h65535);
        convert(9);
        scan_check(9);
        convert(10203);
        scan_check(10203);

        // Change while busy collapses into one follow-up conversion.
        d0 = done_cnt;
        dif.value = 16'd1000;
        exp_q.push_back(to_bcd(1000));
        exp_q.push_back(to_bcd(42));
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dif.value = 16'd42;
        drain();
        check("two_done_pulses", 32'(done_cnt - d0), 32'd2);
        cur = 42;

        // Reset during conversion of 500.
        dif.value = 16'd500;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        d0 = done_cnt;
        tick(3);
        rst_n = 1'b1;
        exp_q.push_back(to_bcd(500));
        drain();
        check("abort_one_done", 32'(done_cnt - d0), 32'd1);
        cur = 500;

        for (int it = 0; it < 25; it++) begin
            v = int'($urandom_range(0, (it % 2) ? 65535 : 99));
            if (v == cur) v = (v + 1) % 65536;
            dif.value = DW'(v);
            exp_q.push_back(to_bcd(v));
            cur = v;
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                tick(int'($urandom_range(1, 6)));
                n = int'($urandom_range(1, 3));
                w = v;
                for (int j = 0; j < n; j++) begin
                    w = int'($urandom_range(0, 65535));
                    dif.value = DW'(w);
                    tick(int'($urandom_range(1, 2)));
                end
                if (w == v) begin
                    w = (w + 1) % 65536;
                    dif.value = DW'(w);
                end
                exp_q.push_back(to_bcd(w));
                cur = w;
            end
            drain();
        end
        tick(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
